// File: rtl/led_frame_sequencer.sv
// led_frame_sequencer: READ/LOAD/TX per pixel, then an inter-frame latch GAP, for an addressable-LED chain
// Ports:
//   clk            system clock, all state changes on the falling edge
//   rst_n          asynchronous active-low reset
//   run            level, keep sequencing frames
//   one_shot       level, sampled on the last GAP cycle, stop after this frame
//   hold_frame     level, sampled on the last GAP cycle, keep the frame index
//   load_sreg      high in the LOAD cycle of each pixel
//   transmit_pixel high in every TX cycle of each pixel
//   pixel, frame   current pixel / frame index
//   frame_start    pulse in the READ cycle of pixel 0
//   frame_done     pulse in the last GAP cycle
//   busy           high in every state except STOP
module led_frame_sequencer #(
  parameter int NUM_PIXELS          = 64,
  parameter int NUM_FRAMES          = 32,
  parameter int BITS_PER_PIXEL      = 24,
  parameter int CYCLES_PER_BIT      = 15,
  parameter int FRAME_PERIOD_CYCLES = 375000,
  parameter int MIN_GAP_CYCLES      = 600,
  localparam int PIX_W = NUM_PIXELS > 1 ? $clog2(NUM_PIXELS) : 1,
  localparam int FRM_W = NUM_FRAMES > 1 ? $clog2(NUM_FRAMES) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             one_shot,
  input  logic             hold_frame,
  output logic             load_sreg,
  output logic             transmit_pixel,
  output logic [PIX_W-1:0] pixel,
  output logic [FRM_W-1:0] frame,
  output logic             frame_start,
  output logic             frame_done,
  output logic             busy
);
  localparam int TX_CYCLES    = BITS_PER_PIXEL * CYCLES_PER_BIT;
  localparam int PIXEL_CYCLES = TX_CYCLES + 2;
  localparam int GAP_RAW      = FRAME_PERIOD_CYCLES - NUM_PIXELS * PIXEL_CYCLES;
  localparam int GAP_MIN      = GAP_RAW > MIN_GAP_CYCLES ? GAP_RAW : MIN_GAP_CYCLES;
  // A zero-length gap cannot be expressed by the counter; one cycle is the floor.
  localparam int GAP_CYCLES   = GAP_MIN > 1 ? GAP_MIN : 1;
  localparam int CNT_MAX      = TX_CYCLES > GAP_CYCLES ? TX_CYCLES : GAP_CYCLES;
  localparam int CNT_W        = CNT_MAX > 1 ? $clog2(CNT_MAX) : 1;
  typedef enum logic [2:0] {S_STOP, S_READ, S_LOAD, S_TX, S_GAP} state_t;
  state_t           r_state, w_state;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic [PIX_W-1:0] r_pixel, w_pixel;
  logic [FRM_W-1:0] r_frame, w_frame;
  logic             w_tx_last, w_gap_last, w_pix_last;
  logic [FRM_W-1:0] w_frm_next;
  assign w_tx_last  = r_cnt == CNT_W'(TX_CYCLES - 1);
  assign w_gap_last = r_cnt == CNT_W'(GAP_CYCLES - 1);
  assign w_pix_last = r_pixel == PIX_W'(NUM_PIXELS - 1);
  assign w_frm_next = r_frame == FRM_W'(NUM_FRAMES - 1) ? '0 : r_frame + FRM_W'(1);
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_pixel = r_pixel;
    w_frame = r_frame;
    case (r_state)
      S_STOP: if (run) begin
        w_state = S_READ;
        w_pixel = '0;
      end
      S_READ: w_state = S_LOAD;
      S_LOAD: begin
        w_state = S_TX;
        w_cnt   = '0;
      end
      S_TX: if (w_tx_last) begin
        w_cnt   = '0;
        w_pixel = w_pix_last ? '0 : r_pixel + PIX_W'(1);
        w_state = w_pix_last ? S_GAP : S_READ;
      end else w_cnt = r_cnt + CNT_W'(1);
      S_GAP: if (w_gap_last) begin
        w_cnt   = '0;
        w_frame = hold_frame ? r_frame : w_frm_next;
        w_state = (one_shot || !run) ? S_STOP : S_READ;
      end else w_cnt = r_cnt + CNT_W'(1);
      default: w_state = S_STOP;
    endcase
  end
  // Outputs are registered from the next-state values so they line up with the state they describe.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_STOP;
      r_cnt          <= '0;
      r_pixel        <= '0;
      r_frame        <= '0;
      load_sreg      <= 1'b0;
      transmit_pixel <= 1'b0;
      frame_start    <= 1'b0;
      frame_done     <= 1'b0;
      busy           <= 1'b0;
    end else begin
      r_state        <= w_state;
      r_cnt          <= w_cnt;
      r_pixel        <= w_pixel;
      r_frame        <= w_frame;
      load_sreg      <= w_state == S_LOAD;
      transmit_pixel <= w_state == S_TX;
      frame_start    <= w_state == S_READ && w_pixel == '0;
      frame_done     <= w_state == S_GAP && w_cnt == CNT_W'(GAP_CYCLES - 1);
      busy           <= w_state != S_STOP;
    end
  end
  assign pixel = r_pixel;
  assign frame = r_frame;
endmodule

// File: tb/tb_led_frame_sequencer.sv
// tb_led_frame_sequencer: directed frame timeline checks for a small 4-pixel, 3-frame configuration
module tb_led_frame_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic       one_shot = 1'b0;
  logic       hold_frame = 1'b0;
  logic       load_sreg, transmit_pixel, frame_start, frame_done, busy;
  logic [1:0] pixel, frame;
  logic       c_load, c_tx, c_fs, c_fd, c_busy;
  logic [1:0] c_pixel, c_frame;
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         c_last = -1;
  int         c_sp = 0;
  logic [8:0] w_vec, c_vec;
  always #5 clk = ~clk;
  led_frame_sequencer #(
    .NUM_PIXELS(4), .NUM_FRAMES(3), .BITS_PER_PIXEL(2), .CYCLES_PER_BIT(3),
    .FRAME_PERIOD_CYCLES(40), .MIN_GAP_CYCLES(5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .one_shot(one_shot), .hold_frame(hold_frame),
    .load_sreg(load_sreg), .transmit_pixel(transmit_pixel), .pixel(pixel), .frame(frame),
    .frame_start(frame_start), .frame_done(frame_done), .busy(busy)
  );
  led_frame_sequencer #(
    .NUM_PIXELS(4), .NUM_FRAMES(3), .BITS_PER_PIXEL(2), .CYCLES_PER_BIT(3),
    .FRAME_PERIOD_CYCLES(20), .MIN_GAP_CYCLES(5)
  ) dut_c (
    .clk(clk), .rst_n(rst_n), .run(run), .one_shot(one_shot), .hold_frame(hold_frame),
    .load_sreg(c_load), .transmit_pixel(c_tx), .pixel(c_pixel), .frame(c_frame),
    .frame_start(c_fs), .frame_done(c_fd), .busy(c_busy)
  );
  assign w_vec = {busy, frame_start, frame_done, load_sreg, transmit_pixel, pixel, frame};
  assign c_vec = {c_busy, c_fs, c_fd, c_load, c_tx, c_pixel, c_frame};
  // Spacing between the first two frame_start pulses of the clamped-gap instance.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (c_fs) begin
      c_last <= cyc;
      if (c_last >= 0 && c_sp == 0) c_sp <= cyc - c_last;
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask
  // Frame offset o: pixel p owns offsets 8p..8p+7 (READ, LOAD, 6x TX); GAP is 32..39.
  function automatic logic [8:0] exp_vec(input int f, input int o);
    logic [1:0] p;
    p = o < 32 ? 2'(o / 8) : 2'd0;
    return {1'b1, o == 0, o == 39, o < 32 && o % 8 == 1, o < 32 && o % 8 >= 2, p, 2'(f)};
  endfunction
  task automatic check_frame(input int f, input int o0, input int o1);
    for (int o = o0; o < o1; o++) begin
      chk($sformatf("f%0d_o%0d", f, o), 32'(w_vec), 32'(exp_vec(f, o)));
      @(posedge clk);
    end
  endtask
  initial begin
    repeat (3) @(posedge clk);
    chk("reset", 32'(w_vec), 32'd0);
    chk("reset_c", 32'(c_vec), 32'd0);
    rst_n = 1'b1;
    run = 1'b1;
    @(posedge clk);
    check_frame(0, 0, 40);
    check_frame(1, 0, 40);
    check_frame(2, 0, 40);
    hold_frame = 1'b1;
    check_frame(0, 0, 40);
    hold_frame = 1'b0;
    one_shot = 1'b1;
    check_frame(0, 0, 40);
    chk("oneshot_stop", 32'(w_vec), 32'(9'd1));
    one_shot = 1'b0;
    @(posedge clk);
    check_frame(1, 0, 17);
    run = 1'b0;
    check_frame(1, 17, 40);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("run_stop%0d", i), 32'(w_vec), 32'(9'd2));
      @(posedge clk);
    end
    run = 1'b1;
    @(posedge clk);
    check_frame(2, 0, 40);
    check_frame(0, 0, 40);
    check_frame(1, 0, 18);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", 32'(w_vec), 32'd0);
    @(posedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    check_frame(0, 0, 40);
    chk("clamp_spacing", 32'(c_sp), 32'd37);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/led_frame_sequencer.md
Name: led_frame_sequencer

Overview:
Parametrised successor to the fixed 64-pixel LED-matrix frame controller. It sequences per-pixel read / shift-register load / serial-transmit phases for an addressable-LED chain, then inserts an inter-frame latch gap. Pixel count, bits per pixel, bit timing, frame count and frame period are generic. Run/stop control, one-shot mode, frame hold and frame-boundary strobes are new. It sits between the frame memory (addressed by pixel/frame) and the pixel shift register/serialiser.

Parameters:
NUM_PIXELS, 64, LEDs in chain (>=1)
NUM_FRAMES, 32, frames in animation before frame index wraps (>=1)
BITS_PER_PIXEL, 24, serial bits per pixel
CYCLES_PER_BIT, 15, clk cycles per serial bit
FRAME_PERIOD_CYCLES, 375000, target clk cycles from one frame start to the next (32 fps at 12 MHz)
MIN_GAP_CYCLES, 600, minimum latch gap (50 us at 12 MHz)

Ports:
clk  in  1  system clock; all state updates on falling edge
rst_n  in  1  asynchronous active-low reset
run  in  1  level; 1 = keep sequencing frames
one_shot  in  1  level; sampled at frame end; 1 = stop after current frame
hold_frame  in  1  level; sampled at frame end; 1 = do not advance frame index
load_sreg  out  1  high for the single LOAD cycle of each pixel
transmit_pixel  out  1  high for every TX cycle of each pixel
pixel  out  PIX_W  current pixel index; PIX_W = max(1, clog2(NUM_PIXELS))
frame  out  FRM_W  current frame index; FRM_W = max(1, clog2(NUM_FRAMES))
frame_start  out  1  one-cycle pulse in the READ cycle of pixel 0
frame_done  out  1  one-cycle pulse in the last GAP cycle
busy  out  1  high in every state except STOP

Behaviour:
- Derived constants (elaboration time, signed arithmetic): TX_CYCLES = BITS_PER_PIXEL*CYCLES_PER_BIT; PIXEL_CYCLES = TX_CYCLES+2; GAP_CYCLES = max(FRAME_PERIOD_CYCLES - NUM_PIXELS*PIXEL_CYCLES, MIN_GAP_CYCLES). Counter widths sized from these constants.
- Reset (async, rst_n=0): state STOP; pixel=0, frame=0; all counters 0; all strobes, load_sreg, transmit_pixel and busy 0.
- FSM states: STOP, READ, LOAD, TX, GAP. Registered state update on negedge clk.
- STOP: all strobes 0. If run=1, go to READ next cycle with pixel=0. Frame index retains its value.
- READ: lasts 1 cycle. frame_start=1 iff pixel==0. Next state is LOAD.
- LOAD: lasts 1 cycle with load_sreg=1. Next state is TX.
- TX: lasts exactly TX_CYCLES cycles with transmit_pixel=1; tx counter runs 0..TX_CYCLES-1.
  - On the last TX cycle, if pixel==NUM_PIXELS-1: pixel wraps to 0 and the FSM goes to GAP.
  - Otherwise pixel increments and the FSM goes to READ.
- GAP: lasts exactly GAP_CYCLES cycles. On the last cycle:
  - frame_done=1.
  - frame advances unless hold_frame=1; it wraps from NUM_FRAMES-1 to 0.
  - Next state is STOP if one_shot=1 or run=0; otherwise READ.
- Frame period with run held high and GAP not clamped = FRAME_PERIOD_CYCLES exactly; frame_start pulses are spaced by that amount.
- run deasserted mid-frame: no truncation. The current pixel, remaining pixels and the full GAP all complete, then the FSM enters STOP. A run toggle inside a frame has no effect.
- one_shot and hold_frame are sampled only on the last GAP cycle.
- NUM_PIXELS=1: pixel stays 0, and READ→LOAD→TX→GAP repeats.
- NUM_FRAMES=1: frame stays 0.
- Reset asserted mid-TX: immediate return to reset values. After release, sequencing restarts from pixel 0 of frame 0 when run=1.
- pixel and frame are stable throughout READ, LOAD and TX of a given pixel.

Test Plan:
- Defaults, run=1, rst_n released: load_sreg pulses 64 times/frame; each transmit_pixel run is 360 cycles; frame_start pulses spaced 375000 cycles; GAP=351832; frame goes 0→1 on first frame_done.
- NUM_PIXELS=4, BITS_PER_PIXEL=2, CYCLES_PER_BIT=3, FRAME_PERIOD=40, MIN_GAP=5: TX=6, GAP=8; frame_start every 40 cycles; pixel sequence 0,1,2,3,0.
- Same as previous but FRAME_PERIOD=20: GAP clamped to 5; frame_start spacing 37 cycles.
- Small config, NUM_FRAMES=3, run=1, hold_frame=0: frame 0,1,2,0. Set hold_frame=1 before a frame_done: frame index unchanged across that boundary.
- one_shot=1, or run dropped during pixel 2: sequence completes pixel 3 and the full GAP; frame_done=1, then busy=0 and STOP. Reasserting run gives frame_start on the next READ.
- rst_n=0 mid-TX of pixel 2 in frame 1: outputs return to 0 asynchronously. After release, first frame_start has pixel=0, frame=0.
